bus_read_port: RTL
==================

# bus_read_port

Registered source side of the 32-bit datapath bus: encodes the one-hot `*out` control strobes into a source code and drives `BusMuxOut` with the selected register's value, one clock after the strobe is sampled. It feeds every bus-loaded register, including R0, and enforces the BAout rule on the drive side: R0 reads as zero when BAout is asserted. It also keeps the last driven value when no source is selected, and records illegal multi-source cycles.

## Interface
- `NSRC`, 24: number of bus sources. Index map: 0–15 = R0–R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C.
- `CNT_W`, 16: width of the drive-cycle counter.
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `out_sel`  in  NSRC  one-hot source strobes; bit i corresponds to source i.
- `BAout`  in  1  base-address read; forces source 0 (R0) to read as zero.
- `src_data`  in  32*NSRC  flattened source values; source i occupies bits [32i+31:32i].
- `BusMuxOut`  out  32  registered bus value.
- `bus_valid`  out  1  high for the cycle after a legal source was sampled.
- `sel_code`  out  5  encoded index of the last legal source.
- `conflict`  out  1  sticky multi-source error flag.
- `drive_count`  out  CNT_W  saturating count of legal drive cycles.
- `count_clr`  in  1  synchronous clear of `drive_count` and `conflict`.

## Operation
- The block samples `out_sel`, `BAout` and `src_data` on every rising edge of `clk`.
- **Single strobe at bit i (legal):**
  - `BusMuxOut` takes `src_data[i]`.
  - If i = 0 and `BAout` = 1, `BusMuxOut` takes 32'h0 instead.
  - `BAout` has no effect for any i ≠ 0.
  - `sel_code` takes i, `bus_valid` goes to 1, and `drive_count` increments.
- **No strobe (idle):**
  - `BusMuxOut` and `sel_code` hold their previous values (bus keeper).
  - `bus_valid` goes to 0 and `drive_count` does not change.
- **Two or more strobes:** behaviour is set under Configuration.
- **drive_count:**
  - Saturates at 2^CNT_W − 1; further increments have no effect.
  - `count_clr` has priority over an increment in the same cycle; the result is 0.
- **conflict:** once set, it stays set until `count_clr` is asserted or reset is applied.
- **Reset (`clr` = 0):** effective immediately, regardless of clock.
  - `BusMuxOut` = 0, `sel_code` = 0, `bus_valid` = 0, `conflict` = 0, `drive_count` = 0.
  - A strobe present while reset is low is ignored.
  - Reset released mid-strobe: the first rising edge after `clr` returns high samples normally.

## Timing
- Latency is 1 cycle: a strobe sampled at edge N appears on `BusMuxOut` and `bus_valid` after edge N and stays valid until edge N+1.
- The receiving register captures `BusMuxOut` at edge N+1. The control unit therefore asserts a register's `*out` strobe one cycle ahead of the destination's `*in` enable.
- Back-to-back strobes on consecutive cycles give back-to-back valid values; there are no bubbles.
- `count_clr` and all counter and flag updates are synchronous to `clk`.

## Configuration
- Macro: `BUS_CONFLICT_CHECK_EN`.
- **Defined:** a cycle with two or more strobes is handled as follows:
  - `conflict` is set and `bus_valid` goes to 0.
  - `BusMuxOut` takes 32'h0.
  - `sel_code` holds its previous value and `drive_count` does not increment.
- **Not defined:** a cycle with two or more strobes is handled as follows:
  - The lowest-index asserted bit wins and the cycle is treated as a legal single-strobe cycle.
  - The BAout rule still applies if bit 0 wins.
  - `conflict` is tied to 0.

## Test plan
- **Reset:**
  - Stimulus: drive `clr` low mid-cycle while `out_sel` = bit 5 and `src_data[5]` = 32'hDEADBEEF.
  - Required response: all outputs go to 0 immediately. After release, the first edge gives `BusMuxOut` = 32'hDEADBEEF, `sel_code` = 5, `bus_valid` = 1.
- **R0 with BAout:**
  - Stimulus: `src_data[0]` = 32'h12345678, `out_sel` = bit 0. First cycle `BAout` = 1, next cycle `BAout` = 0.
  - Required response: `BusMuxOut` = 32'h0, then 32'h12345678.
- **BAout on a non-R0 source:**
  - Stimulus: `out_sel` = bit 20 (PC), `src_data[20]` = 32'h40, `BAout` = 1.
  - Required response: `BusMuxOut` = 32'h40.
- **Idle hold:**
  - Stimulus: strobe bit 17 (LO) with value 32'hA5A5A5A5, then 3 cycles with `out_sel` = 0.
  - Required response: `BusMuxOut` stays 32'hA5A5A5A5, `bus_valid` = 0 for those 3 cycles, `drive_count` = 1.
- **Conflict:**
  - Stimulus: `out_sel` = bits 3 and 9.
  - Required response with the macro defined: `conflict` = 1, `BusMuxOut` = 0. `conflict` persists through later legal cycles until `count_clr` is asserted.
  - Required response with the macro not defined: `BusMuxOut` = `src_data[3]`, `sel_code` = 3.
- **Counter:**
  - Stimulus: run 70000 consecutive legal strobes with CNT_W = 16, then assert `count_clr` together with a strobe.
  - Required response: `drive_count` saturates at 16'hFFFF, then reads 0 after the clear.

Source files
------------

// File: rtl/bus_read_port_if.sv
// bus_read_port_if: source-side bus signals between the control unit and bus_read_port.
// The master drives the strobes, source values and count clear; the slave returns the registered bus.
interface bus_read_port_if #(
    parameter int NSRC  = 24,
    parameter int CNT_W = 16
);
    logic [NSRC-1:0]    out_sel;
    logic               BAout;
    logic [32*NSRC-1:0] src_data;
    logic               count_clr;
    logic [31:0]        BusMuxOut;
    logic               bus_valid;
    logic [4:0]         sel_code;
    logic               conflict;
    logic [CNT_W-1:0]   drive_count;

    modport master (
        output out_sel, BAout, src_data, count_clr,
        input  BusMuxOut, bus_valid, sel_code, conflict, drive_count
    );

    modport slave (
        input  out_sel, BAout, src_data, count_clr,
        output BusMuxOut, bus_valid, sel_code, conflict, drive_count
    );
endinterface

// File: rtl/bus_read_port.sv
// bus_read_port: registered one-hot source mux onto the 32-bit bus with R0/BAout zeroing and keeper.
// Optional BUS_CONFLICT_CHECK_EN: multi-strobe cycles flag conflict and drive zero instead of lowest-index win.
module bus_read_port #(
    parameter int NSRC  = 24,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           clr,
    bus_read_port_if.slave bus
);
    logic [4:0]  idx;
    logic [31:0] sel_data;
    logic        any_sel;
    logic        multi_sel;
    logic        legal;
    logic        clash;

    always_comb begin
        idx = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (bus.out_sel[i]) idx = 5'(i);
        any_sel   = |bus.out_sel;
        multi_sel = |(bus.out_sel & (bus.out_sel - NSRC'(1)));
        sel_data  = (idx == 5'd0 && bus.BAout) ? 32'h0 : bus.src_data[int'(idx) * 32 +: 32];
`ifdef BUS_CONFLICT_CHECK_EN
        legal = any_sel && !multi_sel;
        clash = multi_sel;
`else
        legal = any_sel;
        clash = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.BusMuxOut   <= '0;
            bus.sel_code    <= '0;
            bus.bus_valid   <= 1'b0;
            bus.conflict    <= 1'b0;
            bus.drive_count <= '0;
        end else begin
            bus.bus_valid <= legal;
            if (legal) begin
                bus.BusMuxOut <= sel_data;
                bus.sel_code  <= idx;
            end else if (clash) begin
                bus.BusMuxOut <= 32'h0;
            end
            bus.conflict    <= bus.count_clr ? 1'b0 : (bus.conflict | clash);
            // Clear wins over an increment landing in the same cycle.
            bus.drive_count <= bus.count_clr ? '0 :
                               (legal && bus.drive_count != '1) ? bus.drive_count + CNT_W'(1) :
                               bus.drive_count;
        end
    end
endmodule
